ringosc_freq_counter: RTL and testbench

- Measurement stage directly downstream of the 5-stage ring oscillator.
- Samples the free-running oscillator output `osc_in` in the system clock domain and counts its rising edges over a programmable window of `clk` cycles.
- Returns the edge count with a valid flag, so firmware or the test harness can compute oscillator frequency (f_osc = count * f_clk / win_cycles).
- `osc_in` must be pre-divided externally so that f_osc < f_clk/3.

---
 rtl/ringosc_pkg.sv | 24 ++
 rtl/ringosc_freq_counter_if.sv | 38 +++
 rtl/ringosc_sync_edge.sv | 36 +++
 rtl/ringosc_freq_counter.sv | 142 ++++++++++++++
 tb/tb_ringosc_freq_counter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ringosc_pkg.sv
// Shared types and defaults for the ring-oscillator frequency counter.
// RINGOSC_FC_SATURATE_EN (see ringosc_freq_counter.sv) selects saturating edge counting.
`timescale 1ns/1ps
package ringosc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } ringosc_fc_state_t;

   localparam int RINGOSC_CNT_W           = 16;
   localparam int RINGOSC_WIN_W           = 16;
   localparam int RINGOSC_SYNC_STAGES_DEF = 2;

   // Only 2 or 3 synchronizer flops make sense; anything else falls back to the default depth.
   function automatic int legal_sync_stages(input int requested);
      if (requested == 3)
         return 3;
      return RINGOSC_SYNC_STAGES_DEF;
   endfunction

endpackage

// File: rtl/ringosc_freq_counter_if.sv
// Control/result bundle of the frequency counter: measurement request in, edge count out.
`timescale 1ns/1ps
interface ringosc_freq_counter_if
   import ringosc_pkg::*;
#(
   parameter int CNT_W = RINGOSC_CNT_W,
   parameter int WIN_W = RINGOSC_WIN_W
) ();

   logic             start;
   logic             abort;
   logic [WIN_W-1:0] win_cycles;
   logic             busy;
   logic [CNT_W-1:0] count;
   logic             valid;
   logic             overflow;

   modport master (
      output start,
      output abort,
      output win_cycles,
      input  busy,
      input  count,
      input  valid,
      input  overflow
   );

   modport slave (
      input  start,
      input  abort,
      input  win_cycles,
      output busy,
      output count,
      output valid,
      output overflow
   );

endinterface

// File: rtl/ringosc_sync_edge.sv
// Brings the asynchronous oscillator into the clk domain and flags each rising edge.
`timescale 1ns/1ps
module ringosc_sync_edge
   import ringosc_pkg::*;
#(
   parameter int SYNC_STAGES = RINGOSC_SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   input  logic flush,
   output logic rise
);

   localparam int STAGES = legal_sync_stages(SYNC_STAGES);

   logic [STAGES-1:0] sync_q;
   logic              prev;
   logic              sync_out;

   assign sync_out = sync_q[STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev   <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         prev   <= sync_out;
      end
   end

   // prev keeps tracking while flushed, so an edge seen during flush is never reported later.
   assign rise = sync_out & ~prev & ~flush;

endmodule

// File: rtl/ringosc_freq_counter.sv
// Counts synchronized osc_in rising edges over a window of win_cycles clk cycles.
// Define RINGOSC_FC_SATURATE_EN to make the edge counter saturate instead of wrapping.
`timescale 1ns/1ps
module ringosc_freq_counter
   import ringosc_pkg::*;
#(
   parameter int CNT_W       = RINGOSC_CNT_W,
   parameter int WIN_W       = RINGOSC_WIN_W,
   parameter int SYNC_STAGES = RINGOSC_SYNC_STAGES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   osc_in,
   ringosc_freq_counter_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   ringosc_fc_state_t state;
   ringosc_fc_state_t state_nxt;

   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_nxt;
   logic [CNT_W-1:0] count_r;
   logic             valid_r;
   logic             overflow_r;
   logic             overflow_nxt;

   logic rise;
   logic accept;
   logic do_abort;
   logic enter_done;
   logic bump;
   logic at_max;

   ringosc_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .async_in (osc_in),
      .flush    (state == ARM),
      .rise     (rise)
   );

   // Next-state logic; abort outranks start only while a measurement is running.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      do_abort   = 1'b0;
      enter_done = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = ARM;
            end
         end
         ARM: begin
            if (bus.abort) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end else if (win_cnt == '0) begin
               enter_done = 1'b1;
               state_nxt  = DONE;
            end else begin
               state_nxt = COUNT;
            end
         end
         COUNT: begin
            if (bus.abort) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end else if (win_cnt == WIN_ONE) begin
               enter_done = 1'b1;
               state_nxt  = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Edge counter update, including the rise in the final COUNT cycle that feeds the result.
   always_comb begin
      bump         = (state == COUNT) && !bus.abort && rise;
      at_max       = (edge_cnt == {CNT_W{1'b1}});
      edge_nxt     = edge_cnt;
      overflow_nxt = overflow_r;
      if (bump) begin
         if (at_max) begin
            overflow_nxt = 1'b1;
`ifdef RINGOSC_FC_SATURATE_EN
            edge_nxt     = edge_cnt;
`else
            edge_nxt     = '0;
`endif
         end else begin
            edge_nxt = edge_cnt + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         win_cnt    <= '0;
         edge_cnt   <= '0;
         count_r    <= '0;
         valid_r    <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            win_cnt    <= bus.win_cycles;
            edge_cnt   <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
         end else if (do_abort) begin
            edge_cnt   <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
         end else begin
            if (state == COUNT)
               win_cnt <= win_cnt - WIN_ONE;
            edge_cnt   <= edge_nxt;
            overflow_r <= overflow_nxt;
            if (enter_done) begin
               count_r <= edge_nxt;
               valid_r <= 1'b1;
            end
         end
      end
   end

   assign bus.busy     = (state == ARM) || (state == COUNT);
   assign bus.count    = count_r;
   assign bus.valid    = valid_r;
   assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_ringosc_freq_counter.sv
// Scoreboard bench: a 16-bit counter for functional cases and a 4-bit one for overflow.
`timescale 1ns/1ps
module tb_ringosc_freq_counter;
   import ringosc_pkg::*;

   typedef struct {
      int   lo;
      int   hi;
      logic ovf;
   } exp_t;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic osc_in = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t exp_main[$];
   exp_t exp_small[$];

   ringosc_freq_counter_if #(.CNT_W(16), .WIN_W(16)) main_if ();
   ringosc_freq_counter_if #(.CNT_W(4),  .WIN_W(16)) small_if ();

   ringosc_freq_counter #(
      .CNT_W       (16),
      .WIN_W       (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .osc_in (osc_in),
      .bus    (main_if.slave)
   );

   ringosc_freq_counter #(
      .CNT_W       (4),
      .WIN_W       (16),
      .SYNC_STAGES (3)
   ) dut_small (
      .clk    (clk),
      .rst    (rst),
      .osc_in (osc_in),
      .bus    (small_if.slave)
   );

   always #5 clk = ~clk;

   // 40 ns oscillator, edges placed well away from clk edges so every window sees exactly W/4 rises.
   initial begin
      #3;
      forever #20 osc_in = ~osc_in;
   end

   function automatic void check_output(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endfunction

   function automatic void check_result(input string name, input exp_t e, input int cnt, input logic ovf);
      n_cmp++;
      if (cnt < e.lo || cnt > e.hi) begin
         n_bad++;
         $display("[TB] FAIL %s_count: got %0d, expected %0d..%0d", name, cnt, e.lo, e.hi);
      end
      check_output({name, "_overflow"}, int'(ovf), int'(e.ovf));
   endfunction

   logic prev_valid_main  = 1'b0;
   logic prev_valid_small = 1'b0;

   // Monitors pop one expectation per rising edge of valid.
   always @(negedge clk) begin
      if (main_if.valid && !prev_valid_main) begin
         if (exp_main.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL main_unexpected_result: got count %0d, expected no result", main_if.count);
         end else begin
            check_result("main_result", exp_main.pop_front(), int'(main_if.count), main_if.overflow);
         end
      end
      prev_valid_main = main_if.valid;
   end

   always @(negedge clk) begin
      if (small_if.valid && !prev_valid_small) begin
         if (exp_small.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL small_unexpected_result: got count %0d, expected no result", small_if.count);
         end else begin
            check_result("small_result", exp_small.pop_front(), int'(small_if.count), small_if.overflow);
         end
      end
      prev_valid_small = small_if.valid;
   end

   // Drives one request at a negedge; returns at the negedge after it was sampled.
   task automatic apply_stimulus(input int win, input logic with_start, input logic with_abort);
      main_if.win_cycles = win[15:0];
      main_if.start      = with_start;
      main_if.abort      = with_abort;
      @(negedge clk);
      main_if.start = 1'b0;
      main_if.abort = 1'b0;
   endtask

   task automatic apply_small(input int win);
      small_if.win_cycles = win[15:0];
      small_if.start      = 1'b1;
      @(negedge clk);
      small_if.start = 1'b0;
   endtask

   initial begin
      main_if.start       = 1'b0;
      main_if.abort       = 1'b0;
      main_if.win_cycles  = '0;
      small_if.start      = 1'b0;
      small_if.abort      = 1'b0;
      small_if.win_cycles = '0;

      repeat (2) @(negedge clk);
      check_output("reset_busy",     int'(main_if.busy),     0);
      check_output("reset_count",    int'(main_if.count),    0);
      check_output("reset_valid",    int'(main_if.valid),    0);
      check_output("reset_overflow", int'(main_if.overflow), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] basic 100-cycle window");
      exp_main.push_back('{24, 26, 1'b0});
      apply_stimulus(100, 1'b1, 1'b0);
      check_output("basic_busy_arm", int'(main_if.busy), 1);
      repeat (100) @(negedge clk);
      check_output("basic_busy_last", int'(main_if.busy),  1);
      check_output("basic_valid_early", int'(main_if.valid), 0);
      @(negedge clk);
      check_output("basic_busy_done", int'(main_if.busy),  0);
      check_output("basic_valid_done", int'(main_if.valid), 1);

      $display("[TB] zero window");
      exp_main.push_back('{0, 0, 1'b0});
      apply_stimulus(0, 1'b1, 1'b0);
      check_output("zero_busy_arm", int'(main_if.busy), 1);
      @(negedge clk);
      check_output("zero_valid", int'(main_if.valid), 1);
      check_output("zero_busy",  int'(main_if.busy),  0);

      $display("[TB] start during COUNT ignored");
      exp_main.push_back('{25, 25, 1'b0});
      apply_stimulus(100, 1'b1, 1'b0);
      repeat (30) @(negedge clk);
      apply_stimulus(5, 1'b1, 1'b0);
      repeat (69) @(negedge clk);
      check_output("restart_busy_last", int'(main_if.busy), 1);
      @(negedge clk);
      check_output("restart_valid", int'(main_if.valid), 1);

      $display("[TB] abort mid-window");
      apply_stimulus(1000, 1'b1, 1'b0);
      repeat (299) @(negedge clk);
      apply_stimulus(1000, 1'b0, 1'b1);
      check_output("abort_busy",     int'(main_if.busy),     0);
      check_output("abort_valid",    int'(main_if.valid),    0);
      check_output("abort_count",    int'(main_if.count),    25);
      check_output("abort_overflow", int'(main_if.overflow), 0);
      exp_main.push_back('{24, 26, 1'b0});
      apply_stimulus(100, 1'b1, 1'b0);
      repeat (101) @(negedge clk);

      $display("[TB] start+abort in DONE");
      exp_main.push_back('{5, 5, 1'b0});
      apply_stimulus(20, 1'b1, 1'b1);
      check_output("done_startabort_busy", int'(main_if.busy), 1);
      repeat (21) @(negedge clk);

      $display("[TB] start+abort in COUNT");
      apply_stimulus(100, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      apply_stimulus(7, 1'b1, 1'b1);
      check_output("count_startabort_busy",  int'(main_if.busy),  0);
      check_output("count_startabort_valid", int'(main_if.valid), 0);
      check_output("count_startabort_count", int'(main_if.count), 5);

      $display("[TB] overflow on 4-bit counter");
`ifdef RINGOSC_FC_SATURATE_EN
      exp_small.push_back('{15, 15, 1'b1});
`else
      exp_small.push_back('{9, 9, 1'b1});
`endif
      apply_small(100);
      repeat (101) @(negedge clk);
      check_output("small_busy_done", int'(small_if.busy), 0);

      $display("[TB] async reset mid-COUNT");
      apply_stimulus(100, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_output("areset_busy",     int'(main_if.busy),     0);
      check_output("areset_count",    int'(main_if.count),    0);
      check_output("areset_valid",    int'(main_if.valid),    0);
      check_output("areset_overflow", int'(main_if.overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_output("post_reset_busy",  int'(main_if.busy),  0);
      check_output("post_reset_valid", int'(main_if.valid), 0);

      check_output("main_results_pending",  exp_main.size(),  0);
      check_output("small_results_pending", exp_small.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
